// File: rtl/ms_stage_pkg.sv
// Shared definitions for the M2 memory stage: bus widths, mem_inst bit
// indices, the M1->MS bus layout and the pending-data FSM states.
package ms_stage_pkg;

    localparam int M1_MS_BUS_W = 117;
    localparam int MS_WS_BUS_W = 70;

    localparam int MEM_LW  = 0;
    localparam int MEM_LWL = 1;
    localparam int MEM_LB  = 2;
    localparam int MEM_LBU = 3;
    localparam int MEM_LH  = 4;
    localparam int MEM_LHU = 5;
    localparam int MEM_LWR = 6;
    localparam int MEM_SB  = 7;
    localparam int MEM_SH  = 8;
    localparam int MEM_SW  = 9;
    localparam int MEM_SWL = 10;
    localparam int MEM_SWR = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HAVE = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic        store_flow;
        logic        ex;
        logic [31:0] rt_value;
        logic [11:0] mem_inst;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } m1_bus_t;

    // Flowed stores were already acknowledged upstream; excepted instructions never reach the cache.
    function automatic logic need_ack(input m1_bus_t b);
        return ~b.ex & (b.res_from_mem | ((|b.mem_inst[MEM_SWR:MEM_SB]) & ~b.store_flow));
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: byte/half select with extension and
// the lwl/lwr merge with the old register value.
module load_align
    import ms_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [6:0]  mem_inst,
    input  logic [31:0] rt,
    output logic [31:0] result
);

    logic [3:0][7:0] byte_lane;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = byte_lane[addr];
    assign sel_half = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        if (mem_inst[MEM_LB]) begin
            result = {{24{sel_byte[7]}}, sel_byte};
        end else if (mem_inst[MEM_LBU]) begin
            result = {24'd0, sel_byte};
        end else if (mem_inst[MEM_LH]) begin
            result = {{16{sel_half[15]}}, sel_half};
        end else if (mem_inst[MEM_LHU]) begin
            result = {16'd0, sel_half};
        end else if (mem_inst[MEM_LWL]) begin
            case (addr)
                2'd0:    result = {word[7:0],  rt[23:0]};
                2'd1:    result = {word[15:0], rt[15:0]};
                2'd2:    result = {word[23:0], rt[7:0]};
                default: result = word;
            endcase
        end else if (mem_inst[MEM_LWR]) begin
            case (addr)
                2'd0:    result = word;
                2'd1:    result = {rt[31:24], word[31:8]};
                2'd2:    result = {rt[31:16], word[31:16]};
                default: result = {rt[31:8],  word[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/ms_stage.sv
// M2 memory stage: holds one instruction, waits for the DCache response,
// aligns load data and forwards the result to WB and ID.
module ms_stage
    import ms_stage_pkg::*;
#(
    parameter int M1_TO_MS_BUS_WD = M1_MS_BUS_W,
    parameter int MS_TO_WS_BUS_WD = MS_WS_BUS_W
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       m1s_to_ms_valid,
    input  logic [M1_TO_MS_BUS_WD-1:0] m1s_to_ms_bus,
    input  logic                       data_data_ok,
    input  logic [31:0]                data_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [4:0]                 MS_dest,
    output logic [31:0]                ms_result,
    output logic                       ms_load_stall
);

    m1_bus_t     bus_in;
    m1_bus_t     bus_reg;
    logic        ms_valid_reg;
    ms_state_e   state_reg, state_next;
    logic [31:0] rdata_buf_reg;

    logic        ms_need_ack;
    logic        ms_ready_go;
    logic        accept;
    logic        mem_valid;
    logic        gr_we_eff;
    logic [31:0] load_word;
    logic [31:0] load_value;

    assign bus_in      = m1_bus_t'(m1s_to_ms_bus);
    assign ms_need_ack = need_ack(bus_reg);
    assign ms_ready_go = ~ms_need_ack
                       | ((state_reg == ST_WAIT) & data_data_ok)
                       | (state_reg == ST_HAVE);
    assign ms_allowin  = ~ms_valid_reg | (ms_ready_go & ws_allowin);
    assign accept      = m1s_to_ms_valid & ms_allowin;

    // Whenever the slot turns over, the state follows the incoming instruction, so no stale HAVE survives.
    always_comb begin
        state_next = state_reg;
        if (ms_allowin) begin
            state_next = (m1s_to_ms_valid && need_ack(bus_in)) ? ST_WAIT : ST_IDLE;
        end else if (state_reg == ST_WAIT && data_data_ok) begin
            state_next = ST_HAVE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_reg  <= 1'b0;
            bus_reg       <= '0;
            rdata_buf_reg <= 32'd0;
        end else begin
            if (ms_allowin) begin
                ms_valid_reg <= m1s_to_ms_valid;
            end
            if (accept) begin
                bus_reg <= bus_in;
            end
            if (state_reg == ST_WAIT && data_data_ok && !ms_allowin) begin
                rdata_buf_reg <= data_rdata;
            end
        end
    end

    assign load_word = (state_reg == ST_HAVE) ? rdata_buf_reg : data_rdata;

    load_align u_load_align (
        .word     (load_word),
        .addr     (bus_reg.final_result[1:0]),
        .mem_inst (bus_reg.mem_inst[MEM_LWR:MEM_LW]),
        .rt       (bus_reg.rt_value),
        .result   (load_value)
    );

    assign mem_valid      = bus_reg.res_from_mem & ~bus_reg.ex;
    assign gr_we_eff      = bus_reg.gr_we & ~bus_reg.ex;
    assign ms_result      = mem_valid ? load_value : bus_reg.final_result;
    assign ms_to_ws_valid = ms_valid_reg & ms_ready_go;
    assign ms_to_ws_bus   = {gr_we_eff, bus_reg.dest, ms_result, bus_reg.pc};
    assign MS_dest        = (ms_valid_reg & gr_we_eff) ? bus_reg.dest : 5'd0;
    assign ms_load_stall  = ms_valid_reg & mem_valid & ~ms_ready_go;

`ifndef SYNTHESIS
    // A response is only meaningful while an instruction is waiting for it.
    a_data_ok_in_wait : assert property (
        @(posedge clk) disable iff (!resetn) data_data_ok |-> (state_reg == ST_WAIT)
    );
`endif

endmodule
